pbus_clint: RTL and testbench

- Single-hart Core-Local Interruptor; AXI4-lite slave on the CLINT port of the PBUS crossbar (window 0x0200_0000, 64 KB, offset = addr[15:0]).
- Holds msip, 64-bit mtimecmp and 64-bit free-running mtime.
- Drives machine software and timer interrupt lines, plus the mtime value for the core's time CSR.

---
 rtl/pbus_clint.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_pbus_clint.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_clint.sv
// Single-hart core-local interruptor on an AXI4-lite slave port.
// Holds msip, mtimecmp and a prescaled 64-bit mtime; drives msip/mtip and mtime.
module pbus_clint #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TICK_DIV   = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,

  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,

  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,

  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,

  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,

  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,

  output logic                    msip_o,
  output logic                    mtip_o,
  output logic [63:0]             mtime_o
);

  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  typedef enum logic [2:0] {
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI,
    SEL_NONE
  } reg_sel_e;

  // Word offset (addr[15:2]) to register; byte lane bits are ignored.
  function automatic reg_sel_e decode(input logic [13:0] word_off);
    case (word_off)
      14'h0000: decode = SEL_MSIP;
      14'h1000: decode = SEL_CMP_LO;
      14'h1001: decode = SEL_CMP_HI;
      14'h2FFE: decode = SEL_TIME_LO;
      14'h2FFF: decode = SEL_TIME_HI;
      default:  decode = SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    for (int i = 0; i < 4; i++) begin
      merge_bytes[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
  endfunction

  // Write channel state
  w_state_e    w_state_q, w_state_d;
  logic        awready_q, awready_d;
  logic        wready_q,  wready_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q,  w_held_d;
  logic [13:0] awaddr_q,  awaddr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        bvalid_q,  bvalid_d;
  logic [1:0]  bresp_q,   bresp_d;

  // Read channel state
  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;

  // Timer state
  logic        msip_q,     msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [15:0] presc_q,    presc_d;
  logic        mtip_q,     mtip_d;

  logic        aw_hs, w_hs, aw_have, w_have, wr_fire, ar_hs, tick;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  reg_sel_e    wr_sel, rd_sel;
  logic [31:0] rd_value;

  assign aw_hs   = S_AXI_AWVALID & awready_q;
  assign w_hs    = S_AXI_WVALID  & wready_q;
  assign aw_have = aw_held_q | aw_hs;
  assign w_have  = w_held_q  | w_hs;
  assign wr_addr = aw_hs ? S_AXI_AWADDR[15:2] : awaddr_q;
  assign wr_data = w_hs  ? S_AXI_WDATA        : wdata_q;
  assign wr_strb = w_hs  ? S_AXI_WSTRB        : wstrb_q;
  assign wr_sel  = decode(wr_addr);
  assign wr_fire = (w_state_q == W_IDLE) & aw_have & w_have;

  assign ar_hs   = S_AXI_ARVALID & arready_q;
  assign rd_sel  = decode(S_AXI_ARADDR[15:2]);

  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) awaddr_d = S_AXI_AWADDR[15:2];
        if (w_hs) begin
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (wr_fire) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          // A captured beat closes its own channel until its partner arrives.
          aw_held_d = aw_have;
          w_held_d  = w_have;
          awready_d = ~aw_have;
          wready_d  = ~w_have;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    case (rd_sel)
      SEL_MSIP:    rd_value = {31'd0, msip_q};
      SEL_CMP_LO:  rd_value = mtimecmp_q[31:0];
      SEL_CMP_HI:  rd_value = mtimecmp_q[63:32];
      SEL_TIME_LO: rd_value = mtime_q[31:0];
      SEL_TIME_HI: rd_value = mtime_q[63:32];
      default:     rd_value = 32'd0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d   = rd_value;
          rresp_d   = (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tick       = (presc_q == TICK_LAST);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

    // A software write to mtime replaces this cycle's increment.
    if (wr_fire) begin
      case (wr_sel)
        SEL_MSIP:    if (wr_strb[0]) msip_d = wr_data[0];
        SEL_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  wr_data, wr_strb);
        SEL_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
        SEL_TIME_LO: if (|wr_strb)
          mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wr_data, wr_strb)};
        SEL_TIME_HI: if (|wr_strb)
          mtime_d = {merge_bytes(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        default: ;
      endcase
    end

    mtip_d = (mtime_q >= mtimecmp_q);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      presc_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      mtip_q     <= mtip_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign msip_o        = msip_q;
  assign mtip_o        = mtip_q;
  assign mtime_o       = mtime_q;

  // Protection bits and address bits outside the 64 KB word window are not decoded.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_WIDTH-1:16], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[ADDR_WIDTH-1:16], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pbus_clint.sv
// Directed and randomized checks of pbus_clint against a cycle-count based
// reference model of the CLINT registers, interrupts and AXI4-lite handshakes.
module tb_pbus_clint;

  localparam int         TD     = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        msip_o;
  logic        mtip_o;
  logic [63:0] mtime_o;

  pbus_clint #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TICK_DIV   (TD)
  ) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .msip_o        (msip_o),
    .mtip_o        (mtip_o),
    .mtime_o       (mtime_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference model: register contents plus the number of edges since reset,
  // from which the mtime tick schedule follows directly.
  logic        m_msip;
  logic [63:0] m_cmp;
  logic [63:0] m_time;
  logic        m_mtip;
  int unsigned m_n;
  bit          m_tick;
  bit          m_twr;
  bit          m_wr_pend = 1'b0;
  logic [15:0] m_wr_off;
  logic [31:0] m_wr_data;
  logic [3:0]  m_wr_strb;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic bit mapped(input logic [15:0] off);
    case (off & 16'hFFFC)
      16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] off);
    case (off & 16'hFFFC)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_time[31:0];
      16'hBFFC: return m_time[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_msip = 1'b0;
      m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_time = 64'd0;
      m_mtip = 1'b0;
      m_n    = 0;
    end else begin
      m_tick = (m_n % TD) == TD - 1;
      m_n    = m_n + 1;
      m_mtip = (m_time >= m_cmp);
      m_twr  = 1'b0;
      if (m_wr_pend) begin
        case (m_wr_off & 16'hFFFC)
          16'h0000: if (m_wr_strb[0]) m_msip = m_wr_data[0];
          16'h4000: m_cmp[31:0]  = mrg(m_cmp[31:0],  m_wr_data, m_wr_strb);
          16'h4004: m_cmp[63:32] = mrg(m_cmp[63:32], m_wr_data, m_wr_strb);
          16'hBFF8: if (m_wr_strb != 4'd0) begin
            m_time[31:0] = mrg(m_time[31:0], m_wr_data, m_wr_strb);
            m_twr = 1'b1;
          end
          16'hBFFC: if (m_wr_strb != 4'd0) begin
            m_time[63:32] = mrg(m_time[63:32], m_wr_data, m_wr_strb);
            m_twr = 1'b1;
          end
          default: ;
        endcase
      end
      if (m_tick && !m_twr) m_time = m_time + 64'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and sample #1 after the edge; outputs tracked by the
  // model are compared on every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("msip_o",  64'(msip_o), 64'(m_msip));
      check("mtip_o",  64'(mtip_o), 64'(m_mtip));
      check("mtime_o", mtime_o,     m_time);
    end
  endtask

  // Address and data phases; returns #1 after the edge where the write lands.
  task automatic axi_write_ad(input logic [15:0] off, input logic [31:0] data,
                              input logic [3:0] strb, input int aw_delay, input int w_delay);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    int t = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && t >= aw_delay) begin
        awvalid = 1'b1;
        awaddr  = {16'h0200, off};
        awprot  = 3'($urandom);
      end
      if (!w_done && t >= w_delay) begin
        wvalid = 1'b1;
        wdata  = data;
        wstrb  = strb;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if ((aw_done || aw_hs) && (w_done || w_hs)) begin
        m_wr_off  = off;
        m_wr_data = data;
        m_wr_strb = strb;
        m_wr_pend = 1'b1;
      end
      step();
      m_wr_pend = 1'b0;
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      if (w_done && !aw_done) check("wready_while_aw_missing", 64'(wready), 64'd0);
      if (aw_done && !w_done) check("awready_while_w_missing", 64'(awready), 64'd0);
      t++;
      if (t > 40) begin
        check("write_accept_timeout", 64'({aw_done, w_done}), 64'd3);
        break;
      end
    end
  endtask

  task automatic wait_b(input int hold, input logic [1:0] exp_resp);
    bready = 1'b0;
    check("bvalid_pending", 64'(bvalid), 64'd1);
    check("bresp",          64'(bresp),  64'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      step();
      check("bvalid_held",        64'(bvalid),  64'd1);
      check("bresp_held",         64'(bresp),   64'(exp_resp));
      check("awready_b_pending",  64'(awready), 64'd0);
      check("wready_b_pending",   64'(wready),  64'd0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("bvalid_cleared",   64'(bvalid),  64'd0);
    check("awready_reopened", 64'(awready), 64'd1);
    check("wready_reopened",  64'(wready),  64'd1);
  endtask

  task automatic axi_write(input logic [15:0] off, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay, input int w_delay,
                           input int hold);
    axi_write_ad(off, data, strb, aw_delay, w_delay);
    wait_b(hold, mapped(off) ? OKAY : SLVERR);
  endtask

  task automatic axi_read(input logic [15:0] off, input int hold);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int t = 0;
    arvalid = 1'b1;
    araddr  = {16'h0200, off};
    arprot  = 3'($urandom);
    while (!arready && t < 20) begin
      step();
      t++;
    end
    check("arready_wait", 64'(arready), 64'd1);
    exp_data = model_read(off);
    exp_resp = mapped(off) ? OKAY : SLVERR;
    step();
    arvalid = 1'b0;
    check("rvalid_latency1", 64'(rvalid),  64'd1);
    check("rdata",           64'(rdata),   64'(exp_data));
    check("rresp",           64'(rresp),   64'(exp_resp));
    check("arready_r_busy",  64'(arready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("rvalid_held", 64'(rvalid), 64'd1);
      check("rdata_held",  64'(rdata),  64'(exp_data));
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("rvalid_cleared",   64'(rvalid),  64'd0);
    check("arready_reopened", 64'(arready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pre;
    logic [31:0] exp_pre;
    logic [15:0] offs [7];
    logic [15:0] off;
    int t;

    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h8000, 16'h0008};
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    step();
    step();
    chk_en = 1'b1;
    step();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_mtip",    64'(mtip_o),  64'd0);
    check("rst_mtime",   mtime_o,      64'd0);
    rst = 1'b0;

    // mtimecmp hi reads back its reset value
    axi_read(16'h4004, 0);
    check("cmp_hi_reset_val", 64'(rdata), 64'hFFFF_FFFF);

    // msip set with W leading AW by three cycles, then cleared
    axi_write_ad(16'h0000, 32'h1, 4'hF, 3, 0);
    check("msip_set", 64'(msip_o), 64'd1);
    wait_b(0, OKAY);
    axi_write(16'h0000, 32'h0, 4'hF, 0, 0, 0);
    check("msip_clear", 64'(msip_o), 64'd0);

    // Timer compare at 20
    axi_write(16'hBFFC, 32'h0, 4'hF, 0, 0, 0);
    axi_write(16'hBFF8, 32'h0, 4'hF, 0, 1, 0);
    axi_write(16'h4004, 32'h0, 4'hF, 1, 0, 0);
    axi_write(16'h4000, 32'd20, 4'hF, 0, 0, 0);
    t = 0;
    while (mtime_o != 64'd20 && t < 200) begin
      step();
      t++;
    end
    check("mtime_reaches_20", mtime_o, 64'd20);
    check("mtip_low_at_20",   64'(mtip_o), 64'd0);
    step();
    check("mtip_rises", 64'(mtip_o), 64'd1);
    axi_write_ad(16'h4004, 32'h1, 4'hF, 0, 0);
    check("mtip_before_cmp_effect", 64'(mtip_o), 64'd1);
    step();
    check("mtip_falls", 64'(mtip_o), 64'd0);
    wait_b(0, OKAY);

    // Carry from mtime lo into hi
    axi_write(16'hBFFC, 32'h0, 4'hF, 0, 0, 0);
    axi_write_ad(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0);
    t = 0;
    while (mtime_o[31:0] == 32'hFFFF_FFFF && t < 10) begin
      step();
      t++;
    end
    check("mtime_carry", mtime_o, 64'h1_0000_0000);
    wait_b(0, OKAY);

    // Partial-strobe mtime write landing on a tick edge
    t = 0;
    while ((m_n % TD) != TD - 1 && t < 10) begin
      step();
      t++;
    end
    pre = mtime_o;
    axi_write_ad(16'hBFF8, 32'h0000_AB00, 4'b0010, 0, 0);
    check("mtime_strobe_on_tick", mtime_o, {pre[63:16], 8'hAB, pre[7:0]});
    wait_b(0, OKAY);

    // Unmapped offset
    axi_read(16'h8000, 0);
    check("unmapped_rdata", 64'(rdata), 64'd0);
    axi_write(16'h8000, 32'hDEAD_BEEF, 4'hF, 0, 0, 5);
    axi_read(16'h4000, 1);

    // Same-cycle read and write of mtimecmp lo returns the old value
    check("idle_arready", 64'(arready), 64'd1);
    check("idle_awready", 64'(awready), 64'd1);
    exp_pre = m_cmp[31:0];
    arvalid = 1'b1; araddr = 32'h0200_4000;
    awvalid = 1'b1; awaddr = 32'h0200_4000;
    wvalid  = 1'b1; wdata  = 32'h1234_5678; wstrb = 4'hF;
    m_wr_off = 16'h4000; m_wr_data = 32'h1234_5678; m_wr_strb = 4'hF; m_wr_pend = 1'b1;
    step();
    m_wr_pend = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("same_cycle_rvalid", 64'(rvalid), 64'd1);
    check("same_cycle_old",    64'(rdata),  64'(exp_pre));
    rready = 1'b1;
    step();
    rready = 1'b0;
    wait_b(0, OKAY);
    axi_read(16'h4000, 0);
    check("cmp_lo_written", 64'(rdata), 64'h1234_5678);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      off = offs[$urandom_range(0, 6)] | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(off, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(off, $urandom_range(0, 2));
    end

    // Reset with a write response pending
    axi_write_ad(16'h0000, 32'h1, 4'hF, 0, 0);
    rst = 1'b1;
    step();
    check("midrst_bvalid",  64'(bvalid),  64'd0);
    check("midrst_awready", 64'(awready), 64'd0);
    check("midrst_msip",    64'(msip_o),  64'd0);
    check("midrst_mtime",   mtime_o,      64'd0);
    rst = 1'b0;
    step();
    axi_read(16'h4000, 0);
    check("midrst_cmp_lo", 64'(rdata), 64'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
